// File: rtl/vga_timing_if.sv
// Raster timing bundle: scan coordinates, strobes and delayed sync/blank.
// frame_cnt is present only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if;
  logic        pix_en;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        active;
  logic        line_start;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        blank;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output pix_en, pixel_x, pixel_y, active, line_start, frame_start,
           hsync, vsync, blank
`ifdef VGA_FRAME_CNT_EN
  , output frame_cnt
`endif
  );

  modport slave (
    input  pix_en, pixel_x, pixel_y, active, line_start, frame_start,
           hsync, vsync, blank
`ifdef VGA_FRAME_CNT_EN
  , input  frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel divider, x/y scan counters, sync/blank decode with a
// short delay line. Define VGA_FRAME_CNT_EN to add the completed-frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 1,
  parameter int unsigned PIPE_DLY = 1,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  vga
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
  logic [CNT_W-1:0] pixel_y_q, pixel_y_d;
  logic             div_last_c;
  logic             pix_en_c;
  logic             x_last_c;
  logic             y_last_c;
  logic             active_c;
  logic             in_hs_c;
  logic             in_vs_c;
  logic             hs_raw_c;
  logic             vs_raw_c;
  logic             blank_raw_c;

  // Pixel-rate divider; the strobe is suppressed while reset is held.
  always_comb begin
    div_last_c = (div_cnt_q == DIV_W'(PIX_DIV - 1));
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    if (div_last_c) begin
      div_cnt_d = '0;
    end
    pix_en_c = div_last_c && !rst;
  end

  // Scan counters advance only on the pixel strobe.
  always_comb begin
    x_last_c  = (pixel_x_q == CNT_W'(H_TOTAL - 1));
    y_last_c  = (pixel_y_q == CNT_W'(V_TOTAL - 1));
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (pix_en_c) begin
      if (x_last_c) begin
        pixel_x_d = '0;
        pixel_y_d = y_last_c ? '0 : pixel_y_q + CNT_W'(1);
      end else begin
        pixel_x_d = pixel_x_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
    end
  end

  // Raw decode; forced inactive during reset so the undelayed build also idles cleanly.
  always_comb begin
    active_c    = (pixel_x_q < CNT_W'(H_ACTIVE)) && (pixel_y_q < CNT_W'(V_ACTIVE));
    in_hs_c     = (pixel_x_q >= CNT_W'(HS_START)) && (pixel_x_q < CNT_W'(HS_END));
    in_vs_c     = (pixel_y_q >= CNT_W'(VS_START)) && (pixel_y_q < CNT_W'(VS_END));
    hs_raw_c    = in_hs_c ? HS_POL : ~HS_POL;
    vs_raw_c    = in_vs_c ? VS_POL : ~VS_POL;
    blank_raw_c = ~active_c;
    if (rst) begin
      hs_raw_c    = ~HS_POL;
      vs_raw_c    = ~VS_POL;
      blank_raw_c = 1'b1;
    end
  end

  // Delay line aligns sync/blank with colour coming out of the sprite ROMs.
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign vga.hsync = hs_raw_c;
      assign vga.vsync = vs_raw_c;
      assign vga.blank = blank_raw_c;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_pipe_q;
      logic [PIPE_DLY-1:0] vs_pipe_q;
      logic [PIPE_DLY-1:0] blank_pipe_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hs_pipe_q    <= {PIPE_DLY{~HS_POL}};
          vs_pipe_q    <= {PIPE_DLY{~VS_POL}};
          blank_pipe_q <= {PIPE_DLY{1'b1}};
        end else begin
          hs_pipe_q[0]    <= hs_raw_c;
          vs_pipe_q[0]    <= vs_raw_c;
          blank_pipe_q[0] <= blank_raw_c;
          for (int unsigned i = 1; i < PIPE_DLY; i++) begin
            hs_pipe_q[i]    <= hs_pipe_q[i-1];
            vs_pipe_q[i]    <= vs_pipe_q[i-1];
            blank_pipe_q[i] <= blank_pipe_q[i-1];
          end
        end
      end

      assign vga.hsync = hs_pipe_q[PIPE_DLY-1];
      assign vga.vsync = vs_pipe_q[PIPE_DLY-1];
      assign vga.blank = blank_pipe_q[PIPE_DLY-1];
    end
  endgenerate

`ifdef VGA_FRAME_CNT_EN
  logic [CNT_W-1:0] frame_cnt_q;

  // Counts frames that reached their last pixel; a reset-aborted frame never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (pix_en_c && x_last_c && y_last_c) begin
      frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

  assign vga.pix_en      = pix_en_c;
  assign vga.pixel_x     = pixel_x_q;
  assign vga.pixel_y     = pixel_y_q;
  assign vga.active      = active_c;
  assign vga.line_start  = pix_en_c && (pixel_x_q == '0);
  assign vga.frame_start = pix_en_c && (pixel_x_q == '0) && (pixel_y_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: two small-raster instances (undivided/1-deep
// delay, and divide-by-4/2-deep delay with inverted sync polarity).
module tb_vga_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HSW = 3, HB = 3;
  localparam int unsigned VA = 6, VF = 1, VSW = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HSW + HB;   // 16
  localparam int unsigned VT = VA + VF + VSW + VB;   // 11
  localparam int unsigned FT = HT * VT;              // 176

  typedef struct {
    int unsigned x;
    int unsigned y;
    bit          ls;
    bit          fs;
    bit          act;
    bit          hs;
    bit          vs;
    bit          blk;
    int unsigned fc;
  } rec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  rec_t qa[$];
  rec_t qb[$];

  vga_timing_if ifa ();
  vga_timing_if ifb ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PIX_DIV(1), .PIPE_DLY(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .vga(ifa)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PIX_DIV(4), .PIPE_DLY(2), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .vga(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected scan state for the i-th pixel strobe after reset release.
  function automatic rec_t mk_rec(input int unsigned i, input bit hp, input bit vp);
    rec_t r;
    r.x   = i % HT;
    r.y   = (i / HT) % VT;
    r.ls  = (r.x == 0);
    r.fs  = (r.x == 0) && (r.y == 0);
    r.act = (r.x < HA) && (r.y < VA);
    r.hs  = (r.x >= 10 && r.x <= 12) ? hp : ~hp;
    r.vs  = (r.y >= 7 && r.y <= 8) ? vp : ~vp;
    r.blk = ~r.act;
    r.fc  = (i / FT) % 65536;
    return r;
  endfunction

  function automatic rec_t idle_rec(input bit hp, input bit vp);
    rec_t r;
    r     = mk_rec(0, hp, vp);
    r.hs  = ~hp;
    r.vs  = ~vp;
    r.blk = 1'b1;
    return r;
  endfunction

  task automatic push_vecs(input int na, input int nb);
    for (int i = 0; i < na; i++) qa.push_back(mk_rec(i, 1'b0, 1'b0));
    for (int i = 0; i < nb; i++) qb.push_back(mk_rec(i, 1'b1, 1'b1));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " a.pix_en"},      32'(ifa.pix_en),      32'd0);
    chk({tag, " a.pixel_x"},     32'(ifa.pixel_x),     32'd0);
    chk({tag, " a.pixel_y"},     32'(ifa.pixel_y),     32'd0);
    chk({tag, " a.line_start"},  32'(ifa.line_start),  32'd0);
    chk({tag, " a.frame_start"}, 32'(ifa.frame_start), 32'd0);
    chk({tag, " a.hsync"},       32'(ifa.hsync),       32'd1);
    chk({tag, " a.vsync"},       32'(ifa.vsync),       32'd1);
    chk({tag, " a.blank"},       32'(ifa.blank),       32'd1);
    chk({tag, " b.pix_en"},      32'(ifb.pix_en),      32'd0);
    chk({tag, " b.pixel_x"},     32'(ifb.pixel_x),     32'd0);
    chk({tag, " b.pixel_y"},     32'(ifb.pixel_y),     32'd0);
    chk({tag, " b.hsync"},       32'(ifb.hsync),       32'd0);
    chk({tag, " b.vsync"},       32'(ifb.vsync),       32'd0);
    chk({tag, " b.blank"},       32'(ifb.blank),       32'd1);
`ifdef VGA_FRAME_CNT_EN
    chk({tag, " a.frame_cnt"},   32'(ifa.frame_cnt),   32'd0);
    chk({tag, " b.frame_cnt"},   32'(ifb.frame_cnt),   32'd0);
`endif
  endtask

  // Undelayed fields plus strobe spacing (gap counts sampled clks since the last strobe).
  task automatic chk_rec(input string tag, input int unsigned idx, input rec_t e,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic ls, input logic fs, input logic act,
                         input int gap, input int gap_exp);
    chk($sformatf("%s[%0d].x", tag, idx),   32'(x),   32'(e.x));
    chk($sformatf("%s[%0d].y", tag, idx),   32'(y),   32'(e.y));
    chk($sformatf("%s[%0d].ls", tag, idx),  32'(ls),  32'(e.ls));
    chk($sformatf("%s[%0d].fs", tag, idx),  32'(fs),  32'(e.fs));
    chk($sformatf("%s[%0d].act", tag, idx), 32'(act), 32'(e.act));
    chk($sformatf("%s[%0d].gap", tag, idx), 32'(gap), 32'(gap_exp));
  endtask

  // Monitor A: one-clk delay, so delayed outputs reflect the previous pixel.
  rec_t        prev_a;
  int          gap_a;
  int unsigned idx_a;
  always @(negedge clk) begin
    if (rst) begin
      gap_a  = 0;
      idx_a  = 0;
      prev_a = idle_rec(1'b0, 1'b0);
    end else begin
      gap_a++;
      if (ifa.pix_en) begin
        if (qa.size() > 0) begin
          rec_t e;
          e = qa.pop_front();
          chk_rec("a", idx_a, e, ifa.pixel_x, ifa.pixel_y, ifa.line_start,
                  ifa.frame_start, ifa.active, gap_a, 1);
          chk($sformatf("a[%0d].hsync", idx_a), 32'(ifa.hsync), 32'(prev_a.hs));
          chk($sformatf("a[%0d].vsync", idx_a), 32'(ifa.vsync), 32'(prev_a.vs));
          chk($sformatf("a[%0d].blank", idx_a), 32'(ifa.blank), 32'(prev_a.blk));
`ifdef VGA_FRAME_CNT_EN
          chk($sformatf("a[%0d].fcnt", idx_a), 32'(ifa.frame_cnt), 32'(e.fc));
`endif
          prev_a = e;
          idx_a++;
        end
        gap_a = 0;
      end
    end
  end

  // Monitor B: pixel held 4 clks, strobe on the last, 2-clk delay stays within the pixel.
  int          gap_b;
  int unsigned idx_b;
  always @(negedge clk) begin
    if (rst) begin
      gap_b = 0;
      idx_b = 0;
    end else begin
      gap_b++;
      if (ifb.pix_en) begin
        if (qb.size() > 0) begin
          rec_t e;
          e = qb.pop_front();
          chk_rec("b", idx_b, e, ifb.pixel_x, ifb.pixel_y, ifb.line_start,
                  ifb.frame_start, ifb.active, gap_b, 4);
          chk($sformatf("b[%0d].hsync", idx_b), 32'(ifb.hsync), 32'(e.hs));
          chk($sformatf("b[%0d].vsync", idx_b), 32'(ifb.vsync), 32'(e.vs));
          chk($sformatf("b[%0d].blank", idx_b), 32'(ifb.blank), 32'(e.blk));
`ifdef VGA_FRAME_CNT_EN
          chk($sformatf("b[%0d].fcnt", idx_b), 32'(ifb.frame_cnt), 32'(e.fc));
`endif
          idx_b++;
        end
        gap_b = 0;
      end
    end
  end

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((qa.size() > 0 || qb.size() > 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (qa.size() > 0 || qb.size() > 0) begin
      n_bad++;
      $display("FAIL %s drain timeout left_a=%0d left_b=%0d required=0", tag,
               qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("por");

    // Two full small frames plus a few lines on A; B crosses several lines.
    @(posedge clk);
    #1;
    push_vecs(2 * FT + 40, 150);
    rst = 1'b0;
    drain("run1");

    // Mid-frame asynchronous reset: outputs must idle before any clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    repeat (3) @(posedge clk);
    #1;
    push_vecs(FT + 30, 60);
    rst = 1'b0;
    drain("run2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
